// File: rtl/xbar_sync_ctrl_if.sv
// Signal bundle between the hash-build processors and the crossbar sync controller.
// The slave modport is the controller's view; master drives the processor-side inputs.
interface xbar_sync_ctrl_if #(
    parameter int NUM_PROC = 3,
    parameter int STATE_W  = 4,
    parameter int IDX_W    = 7
);
    localparam int STG_W = $clog2(NUM_PROC + 1);

    logic [NUM_PROC*STATE_W-1:0] norm_state;
    logic [NUM_PROC*IDX_W-1:0]   norm_index;
    logic [NUM_PROC*STATE_W-1:0] clam_state;
    logic [NUM_PROC*IDX_W-1:0]   clam_index;
    logic [NUM_PROC*IDX_W-1:0]   sw_index;
    logic [NUM_PROC-1:0]         norm_wait;
    logic [NUM_PROC-1:0]         clam_wait;
    logic                        xfer_clr;

    logic [NUM_PROC-1:0]         norm_irq;
    logic [NUM_PROC-1:0]         clam_irq;
    logic [NUM_PROC-1:0]         norm_xfer;
    logic [NUM_PROC-1:0]         clam_xfer;
    logic [NUM_PROC-1:0]         cont;
    logic [STG_W-1:0]            stage;

    modport master (
        output norm_state, norm_index, clam_state, clam_index, sw_index,
        output norm_wait, clam_wait, xfer_clr,
        input  norm_irq, clam_irq, norm_xfer, clam_xfer, cont, stage
    );

    modport slave (
        input  norm_state, norm_index, clam_state, clam_index, sw_index,
        input  norm_wait, clam_wait, xfer_clr,
        output norm_irq, clam_irq, norm_xfer, clam_xfer, cont, stage
    );
endinterface

// File: rtl/xbar_sync_ctrl.sv
// Crossbar sync controller: per-datapath handover interrupts with sticky transfer
// flags, plus a staged barrier that releases a growing set of processors.
module xbar_sync_ctrl #(
    parameter int NUM_PROC     = 3,
    parameter int STATE_W      = 4,
    parameter int IDX_W        = 7,
    parameter int HASHBUILD    = 8,
    parameter int STAGE_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    xbar_sync_ctrl_if.slave bus
);
    localparam int STG_W = $clog2(NUM_PROC + 1);
    localparam int CNT_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [STG_W-1:0]   STG_LAST = STG_W'(NUM_PROC);
    localparam logic [STG_W-1:0]   STG_FIRST = STG_W'(1);
    localparam logic [STATE_W-1:0] HB_CODE  = STATE_W'(HASHBUILD);

    typedef enum logic {RAMP, STEADY} bar_state_t;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_LAST) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [STG_W-1:0] stg_sat_inc(input logic [STG_W-1:0] s);
        return (s == STG_LAST) ? s : s + STG_W'(1);
    endfunction

    // ---- stage p0: input decode ----
    logic [NUM_PROC-2:0] norm_hit_p0, clam_hit_p0;

    for (genvar p = 0; p < NUM_PROC - 1; p++) begin : g_hit
        assign norm_hit_p0[p] =
            (bus.norm_state[p*STATE_W +: STATE_W] == HB_CODE) &&
            (bus.norm_index[p*IDX_W +: IDX_W] == bus.sw_index[p*IDX_W +: IDX_W]);
        assign clam_hit_p0[p] =
            (bus.clam_state[p*STATE_W +: STATE_W] == HB_CODE) &&
            (bus.clam_index[p*IDX_W +: IDX_W] == bus.sw_index[p*IDX_W +: IDX_W]);
    end

    // The last processor has no successor, so its compare inputs are ignored.
    logic unused_last_proc;
    assign unused_last_proc = ^{bus.norm_state[(NUM_PROC-1)*STATE_W +: STATE_W],
                                bus.clam_state[(NUM_PROC-1)*STATE_W +: STATE_W],
                                bus.norm_index[(NUM_PROC-1)*IDX_W +: IDX_W],
                                bus.clam_index[(NUM_PROC-1)*IDX_W +: IDX_W],
                                bus.sw_index[(NUM_PROC-1)*IDX_W +: IDX_W]};

    logic [NUM_PROC-2:0] norm_irq_p0, clam_irq_p0;
    logic [NUM_PROC-2:0] norm_irq_p1, clam_irq_p1;
    logic [NUM_PROC-1:1] norm_xfer_p0, clam_xfer_p0;
    logic [NUM_PROC-1:1] norm_xfer_p1, clam_xfer_p1;

    // A set always beats the wait-driven clear; otherwise the level holds.
    always_comb begin
        norm_irq_p0 = norm_hit_p0 | (~bus.norm_wait[NUM_PROC-2:0] & norm_irq_p1);
        clam_irq_p0 = clam_hit_p0 | (~bus.clam_wait[NUM_PROC-2:0] & clam_irq_p1);
    end

    // Transfer flag p+1 follows irq p by one clock and outranks xfer_clr.
    always_comb begin
        norm_xfer_p0 = (norm_xfer_p1 & ~{(NUM_PROC-1){bus.xfer_clr}}) | norm_irq_p1;
        clam_xfer_p0 = (clam_xfer_p1 & ~{(NUM_PROC-1){bus.xfer_clr}}) | clam_irq_p1;
    end

    bar_state_t          st_p0, st_p1;
    logic [STG_W-1:0]    stage_p0, stage_p1;
    logic [CNT_W-1:0]    cnt_p0, cnt_p1;
    logic [NUM_PROC-1:0] cont_p0, cont_p1;
    logic [NUM_PROC-1:0] both_wait_p0, act_mask_p0, rel_mask_p0;
    logic                go_p0, all_wait_p0;

    // Active set is procs 0..s-1; a release covers procs 0..min(s, NUM_PROC-1).
    always_comb begin
        both_wait_p0 = bus.norm_wait & bus.clam_wait;
        act_mask_p0  = '0;
        rel_mask_p0  = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            act_mask_p0[i] = (STG_W'(i) < stage_p1);
            rel_mask_p0[i] = (STG_W'(i) <= stage_p1);
        end
        go_p0       = &(both_wait_p0 | ~act_mask_p0);
        all_wait_p0 = &both_wait_p0;
    end

    always_comb begin
        st_p0    = st_p1;
        stage_p0 = stage_p1;
        cnt_p0   = cnt_p1;
        cont_p0  = '0;
        unique case (st_p1)
            RAMP: begin
                if (go_p0) begin
                    cont_p0 = rel_mask_p0;
                    if (cnt_p1 == CNT_LAST) begin
                        cnt_p0   = '0;
                        stage_p0 = stg_sat_inc(stage_p1);
                        if (stg_sat_inc(stage_p1) == STG_LAST) begin
                            st_p0 = STEADY;
                        end
                    end else begin
                        cnt_p0 = cnt_sat_inc(cnt_p1);
                    end
                end
            end
            STEADY: begin
                stage_p0 = STG_LAST;
                cont_p0  = all_wait_p0 ? '1 : '0;
            end
            default: st_p0 = RAMP;
        endcase
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            norm_irq_p1  <= '0;
            clam_irq_p1  <= '0;
            norm_xfer_p1 <= '0;
            clam_xfer_p1 <= '0;
            st_p1        <= RAMP;
            stage_p1     <= STG_FIRST;
            cnt_p1       <= '0;
            cont_p1      <= '0;
        end else begin
            norm_irq_p1  <= norm_irq_p0;
            clam_irq_p1  <= clam_irq_p0;
            norm_xfer_p1 <= norm_xfer_p0;
            clam_xfer_p1 <= clam_xfer_p0;
            st_p1        <= st_p0;
            stage_p1     <= stage_p0;
            cnt_p1       <= cnt_p0;
            cont_p1      <= cont_p0;
        end
    end

    assign bus.norm_irq  = {1'b0, norm_irq_p1};
    assign bus.clam_irq  = {1'b0, clam_irq_p1};
    assign bus.norm_xfer = {norm_xfer_p1, 1'b0};
    assign bus.clam_xfer = {clam_xfer_p1, 1'b0};
    assign bus.cont      = cont_p1;
    assign bus.stage     = stage_p1;
endmodule
